// File: rtl/char_grid_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | char_grid_walker: steps a (col,row) cursor over a COLS x ROWS cell grid.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module char_grid_walker #(
  parameter int COLS   = 4,
  parameter int ROWS   = 8,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 8,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int AW    = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          col_major,
  input  logic          wrap_en,
  input  logic          finishedCharacter,
  output logic [CW-1:0] col_idx,
  output logic [RW-1:0] row_idx,
  output logic [X_W-1:0] cell_x,
  output logic [Y_W-1:0] cell_y,
  output logic [AW-1:0] cell_addr,
  output logic          busy,
  output logic          last_cell,
  output logic          frame_done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           cm_q, cm_d;
  logic           we_q, we_d;
  logic           done_q, done_d;

  logic col_at_max;
  logic row_at_max;
  logic at_last;

  assign col_at_max = (col_q == CW'(COLS - 1));
  assign row_at_max = (row_q == RW'(ROWS - 1));
  assign at_last    = col_at_max && row_at_max;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    cm_d    = cm_q;
    we_d    = we_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = RUN;
      col_d   = '0;
      row_d   = '0;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
      cm_d    = col_major;
      we_d    = wrap_en;
    end else if (state_q == RUN && finishedCharacter) begin
      if (at_last) begin
        col_d  = '0;
        row_d  = '0;
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        done_d = 1'b1;
        if (!we_q) state_d = IDLE;
      end else if (!cm_q) begin
        // Row-major: stepping to the next row start also advances addr by one.
        addr_d = addr_q + AW'(1);
        if (col_at_max) begin
          col_d = '0;
          x_d   = '0;
          row_d = row_q + RW'(1);
          y_d   = y_q + Y_W'(CHAR_H);
        end else begin
          col_d = col_q + CW'(1);
          x_d   = x_q + X_W'(CHAR_W);
        end
      end else begin
        if (row_at_max) begin
          row_d  = '0;
          y_d    = '0;
          col_d  = col_q + CW'(1);
          x_d    = x_q + X_W'(CHAR_W);
          addr_d = AW'(col_q) + AW'(1);
        end else begin
          row_d  = row_q + RW'(1);
          y_d    = y_q + Y_W'(CHAR_H);
          addr_d = addr_q + AW'(COLS);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      cm_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      cm_q    <= cm_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign col_idx    = col_q;
  assign row_idx    = row_q;
  assign cell_x     = x_q;
  assign cell_y     = y_q;
  assign cell_addr  = addr_q;
  assign busy       = (state_q == RUN);
  assign last_cell  = busy && at_last;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_char_grid_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_char_grid_walker: 4x8, 1x1 and 5x3 walkers against a frame-index model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_char_grid_walker;

  logic clock = 1'b0;
  logic reset, start, col_major, wrap_en, fc;
  always #5 clock = ~clock;

  // Instance 0: 4x8
  logic [1:0] c0; logic [2:0] r0; logic [7:0] x0; logic [6:0] y0; logic [4:0] a0;
  logic b0, l0, f0;
  // Instance 1: 1x1
  logic [0:0] c1; logic [0:0] r1; logic [7:0] x1; logic [6:0] y1; logic [0:0] a1;
  logic b1, l1, f1;
  // Instance 2: 5x3
  logic [2:0] c2; logic [1:0] r2; logic [7:0] x2; logic [6:0] y2; logic [3:0] a2;
  logic b2, l2, f2;

  char_grid_walker #(.COLS(4), .ROWS(8)) u0 (
    .clock(clock), .reset(reset), .start(start), .col_major(col_major),
    .wrap_en(wrap_en), .finishedCharacter(fc), .col_idx(c0), .row_idx(r0),
    .cell_x(x0), .cell_y(y0), .cell_addr(a0), .busy(b0), .last_cell(l0),
    .frame_done(f0));
  char_grid_walker #(.COLS(1), .ROWS(1)) u1 (
    .clock(clock), .reset(reset), .start(start), .col_major(col_major),
    .wrap_en(wrap_en), .finishedCharacter(fc), .col_idx(c1), .row_idx(r1),
    .cell_x(x1), .cell_y(y1), .cell_addr(a1), .busy(b1), .last_cell(l1),
    .frame_done(f1));
  char_grid_walker #(.COLS(5), .ROWS(3)) u2 (
    .clock(clock), .reset(reset), .start(start), .col_major(col_major),
    .wrap_en(wrap_en), .finishedCharacter(fc), .col_idx(c2), .row_idx(r2),
    .cell_x(x2), .cell_y(y2), .cell_addr(a2), .busy(b2), .last_cell(l2),
    .frame_done(f2));

  int vectors = 0;
  int miscompares = 0;

  // Model: position in frame order plus latched modes, per instance.
  int NC[3] = '{4, 1, 5};
  int NR[3] = '{8, 1, 3};
  int p[3];
  bit run[3], mcm[3], mwe[3], mfd[3];

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_model();
    for (int k = 0; k < 3; k++) begin
      mfd[k] = 1'b0;
      if (reset) begin
        run[k] = 0; p[k] = 0; mcm[k] = 0; mwe[k] = 0;
      end else if (start) begin
        run[k] = 1; p[k] = 0; mcm[k] = col_major; mwe[k] = wrap_en;
      end else if (run[k] && fc) begin
        if (p[k] == NC[k] * NR[k] - 1) begin
          p[k] = 0; mfd[k] = 1'b1;
          if (!mwe[k]) run[k] = 0;
        end else begin
          p[k]++;
        end
      end
    end
  endtask

  task automatic cmp(int k, int col, int row, int x, int y, int addr,
                     int b, int lc, int fd);
    int ec, er;
    if (mcm[k]) begin
      er = p[k] % NR[k]; ec = p[k] / NR[k];
    end else begin
      ec = p[k] % NC[k]; er = p[k] / NC[k];
    end
    chk($sformatf("d%0d_col", k), col, ec);
    chk($sformatf("d%0d_row", k), row, er);
    chk($sformatf("d%0d_x", k), x, ec * 8);
    chk($sformatf("d%0d_y", k), y, er * 8);
    chk($sformatf("d%0d_addr", k), addr, er * NC[k] + ec);
    chk($sformatf("d%0d_busy", k), b, int'(run[k]));
    chk($sformatf("d%0d_last", k), lc, int'(run[k] && p[k] == NC[k] * NR[k] - 1));
    chk($sformatf("d%0d_done", k), fd, int'(mfd[k]));
  endtask

  task automatic cyc(bit r, bit s, bit cm, bit we, bit f);
    reset = r; start = s; col_major = cm; wrap_en = we; fc = f;
    @(posedge clock);
    step_model();
    #1;
    cmp(0, int'(c0), int'(r0), int'(x0), int'(y0), int'(a0), int'(b0), int'(l0), int'(f0));
    cmp(1, int'(c1), int'(r1), int'(x1), int'(y1), int'(a1), int'(b1), int'(l1), int'(f1));
    cmp(2, int'(c2), int'(r2), int'(x2), int'(y2), int'(a2), int'(b2), int'(l2), int'(f2));
  endtask

  initial begin
    int fdn, fd_first, fd_gap;
    reset = 1; start = 0; col_major = 0; wrap_en = 0; fc = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_busy", int'(b0), 0);
    chk("reset_addr", int'(a0), 0);

    // Row-major one-shot frame
    cyc(0, 1, 0, 0, 0);
    chk("start_busy", int'(b0), 1);
    chk("start_1x1_last", int'(l1), 1);
    fdn = 0;
    for (int i = 0; i < 5; i++) begin cyc(0, 0, 0, 0, 1); fdn += int'(f0); end
    chk("rm5_col", int'(c0), 1);
    chk("rm5_row", int'(r0), 1);
    chk("rm5_addr", int'(a0), 5);
    chk("rm5_x", int'(x0), 8);
    chk("rm5_y", int'(y0), 8);
    for (int i = 5; i < 32; i++) begin cyc(0, 0, 0, 0, 1); fdn += int'(f0); end
    chk("rm_done_count", fdn, 1);
    chk("rm_done_last", int'(f0), 1);
    cyc(0, 0, 0, 0, 0);
    chk("rm_idle_after", int'(b0), 0);

    // Pulses in IDLE are ignored
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("idle_addr", int'(a0), 0);

    // Column-major
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    chk("cm10_col", int'(c0), 1);
    chk("cm10_row", int'(r0), 2);
    chk("cm10_addr", int'(a0), 9);
    chk("cm10_y", int'(y0), 16);

    // Reset mid-frame
    cyc(1, 0, 0, 0, 1);
    chk("midrst_busy", int'(b0), 0);
    chk("midrst_done", int'(f0), 0);
    chk("midrst_row", int'(r0), 0);

    // Continuous, back-to-back
    cyc(0, 1, 0, 1, 0);
    fdn = 0; fd_first = -1; fd_gap = -1;
    for (int i = 0; i < 64; i++) begin
      cyc(0, 0, 0, 0, 1);
      if (f0) begin
        if (fdn == 0) fd_first = i; else fd_gap = i - fd_first;
        fdn++;
      end
    end
    chk("wrap_done_count", fdn, 2);
    chk("wrap_done_gap", fd_gap, 32);
    chk("wrap_busy", int'(b0), 1);

    // start beats finishedCharacter at (2,5)
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 22; i++) cyc(0, 0, 0, 0, 1);
    chk("prio_pre_col", int'(c0), 2);
    chk("prio_pre_row", int'(r0), 5);
    cyc(0, 1, 1, 1, 1);
    chk("prio_col", int'(c0), 0);
    chk("prio_row", int'(r0), 0);
    chk("prio_done", int'(f0), 0);
    chk("prio_busy", int'(b0), 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    chk("prio_relatch_addr", int'(a0), 1);

    // start with reset: reset wins
    cyc(1, 1, 0, 0, 0);
    chk("rst_vs_start", int'(b0), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(63) == 0, $urandom_range(31) == 0,
          1'($urandom), 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/char_grid_walker.md
# char_grid_walker

Parametrised character-grid sequencer for the VGA text path. It steps a (column, row) cursor across a COLS×ROWS grid of character cells, advancing one cell per `finishedCharacter` pulse from the glyph drawer. It supports row-major or column-major order and one-shot or continuous (wrapping) frames. It also provides the cell's pixel origin and linear cell address, so the glyph drawer and character RAM can be driven directly.

## Interface
- `COLS`, default 4: cells per row, ≥1.
- `ROWS`, default 8: cells per column, ≥1.
- `CHAR_W`, default 8: cell width in pixels.
- `CHAR_H`, default 8: cell height in pixels.
- `X_W`, default 8: pixel x width; must hold (COLS-1)·CHAR_W.
- `Y_W`, default 7: pixel y width; must hold (ROWS-1)·CHAR_H.
- Derived: `CW` = max(1, clog2(COLS)), `RW` = max(1, clog2(ROWS)), `AW` = max(1, clog2(COLS·ROWS)).

Ports:
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin or restart a frame; mode inputs are sampled on this cycle.
- `col_major`  in  1  sampled at start. 0: column advances first. 1: row advances first.
- `wrap_en`  in  1  sampled at start. 1: continuous frames. 0: one frame, then idle.
- `finishedCharacter`  in  1  one-cycle pulse; the current cell is done.
- `col_idx`  out  CW  current cell column.
- `row_idx`  out  RW  current cell row.
- `cell_x`  out  X_W  pixel origin x = col_idx·CHAR_W.
- `cell_y`  out  Y_W  pixel origin y = row_idx·CHAR_H.
- `cell_addr`  out  AW  linear address = row_idx·COLS + col_idx.
- `busy`  out  1  high in RUN.
- `last_cell`  out  1  busy and the cursor is on the final cell of the current order.
- `frame_done`  out  1  one-cycle pulse; the final cell was accepted.

## Operation
- The FSM has two states.
  - IDLE: the cursor is held at (0,0). `finishedCharacter` is ignored.
  - RUN: the cursor advances on each accepted `finishedCharacter`.
- IDLE→RUN on `start`: cursor set to (0,0); `col_major` and `wrap_en` are latched into internal mode registers.
- In RUN, `start` has priority over `finishedCharacter`. It restarts the frame: cursor to (0,0), modes re-latched, no `frame_done`.
- Row-major advance:
  - If col < COLS-1, col+1.
  - Otherwise col←0, and row+1, or row←0 if row = ROWS-1.
- Column-major advance:
  - If row < ROWS-1, row+1.
  - Otherwise row←0, and col+1, or col←0 if col = COLS-1.
- Final cell:
  - Row-major: (COLS-1, ROWS-1).
  - Column-major: (COLS-1, ROWS-1) is also reached last; the final cell is (COLS-1, ROWS-1) in both orders.
- Accepting `finishedCharacter` on the final cell:
  - Cursor returns to (0,0) and `frame_done` pulses.
  - If latched `wrap_en`=1, stay in RUN; otherwise go to IDLE.
- `cell_x`, `cell_y` and `cell_addr` are registered and updated on the same edge as the indices. They never disagree with the indices, and no multiplier is required; incremental update is allowed.
- If COLS=1 or ROWS=1, the unit dimension stays at 0 and the index width is 1 bit.

## Timing
- Reset (synchronous, highest priority): IDLE, all indices and coordinates 0, `busy`=0, `frame_done`=0, mode registers 0.
- `start` sampled at edge N: `busy`=1 and cursor (0,0) visible after N.
- `finishedCharacter` sampled at edge N in RUN: the new cursor is visible after N, giving one cycle of latency.
- Back-to-back `finishedCharacter` pulses, one every cycle, advance one cell per cycle with no bubbles.
- `frame_done` is high for exactly the cycle after the edge that accepted the final cell.
- One-shot mode: `busy` falls on that same edge.
- `last_cell` is combinational from registered state, so it is valid in the same cycle as the cursor.
- Reset asserted mid-frame aborts the frame with no `frame_done`.
- `start` together with `reset`: reset wins.

## Test plan
- **Reset and idle:** assert reset with the cursor mid-frame → all outputs 0 next cycle. Then pulse `finishedCharacter` in IDLE → cursor stays (0,0).
- **Default row-major, one-shot:** `start` (col_major=0, wrap_en=0), then 32 pulses →
  - order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,7);
  - `cell_addr` 0..31;
  - `cell_x`=col·8;
  - `frame_done` once after pulse 32, then `busy`=0.
- **Column-major:** `start` (col_major=1) → order (0,0),(0,1)…(0,7),(1,0)…(3,7); `cell_addr` 0,4,8…28,1,5…31.
- **Continuous:** wrap_en=1, 64 back-to-back pulses → two `frame_done` pulses 32 cycles apart; `busy` stays 1.
- **Priority:** `start` and `finishedCharacter` in the same cycle at cursor (2,5) → cursor (0,0), no `frame_done`, modes re-latched.
- **Parameter sweep:** COLS=1, ROWS=1 → `last_cell` is always 1 in RUN; every pulse gives `frame_done`. COLS=5, ROWS=3 (non-power-of-2) → wrap occurs at col 4 and row 2.
